spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- 32-bit SPI master that drives the FPGA's existing 32-bit SPI slave port. Used for board-level bring-up, loopback self-test and FPGA-to-FPGA control links.
- Sends one command word per frame, MSB first, with SSEL active low, SCK idle low, mode 0.
- Captures the 16-bit read-back word the slave shifts out during the first 16 bits of the frame.
- Timing is generous because the slave oversamples SCK, SSEL and MOSI through 2-3 flop synchronisers on its own clk.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles; must be >= 4 to cover the slave's synchroniser delay.
SETUP_CYC, 4, cycles from SSEL falling to the first SCK rising edge; must be >= 4.
HOLD_CYC, 4, cycles from the last SCK falling edge to SSEL rising; must be >= 1.
GAP_CYC, 4, minimum SSEL-high cycles before the next frame may start; must be >= 3 so the slave resets its bit counter.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a frame; sampled only when busy=0
tx_data  input  32  command word; latched on accepted start
busy  output  1  high from the cycle after an accepted start until the frame plus gap completes
done  output  1  one-cycle pulse when a frame completes; rx_data is valid in the same cycle
rx_data  output  16  read-back word; holds until the next done
SCK  output  1  SPI clock, idle 0
MOSI  output  1  serial data out, MSB first
SSEL  output  1  chip select, active low
MISO  input  1  serial data from slave; unsynchronised, registered once before use

Behaviour:
- Reset (rst=1 at a clk edge), next cycle:
  - SSEL=1, SCK=0, MOSI=0, busy=0, done=0, rx_data=16'h0000.
  - State=IDLE; all counters and shift registers cleared.
- Reset mid-frame: same values, no done pulse. SSEL rising ends the frame for the slave.
- All outputs are registered.
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- IDLE:
  - Outputs are SSEL=1, SCK=0.
  - start=1 at edge 0 latches tx_data into a 32-bit shift register.
  - At cycle 1: SSEL=0, MOSI=tx_data[31], busy=1, bitcnt=0; go to SETUP.
- SETUP: lasts SETUP_CYC cycles; then SCK=1 and the state becomes SCK_HI.
- SCK_HI:
  - On entry, if bitcnt<16, the registered MISO is shifted into rx_shift (left shift, LSB in).
  - Lasts CLK_DIV cycles, then SCK=0.
  - If bitcnt==31, go to HOLD.
  - Otherwise bitcnt+1, MOSI takes the next bit in the same cycle SCK falls, and go to SCK_LO.
- SCK_LO: lasts CLK_DIV cycles, then SCK=1 and go to SCK_HI.
- Rising-edge timing: bit k rises at cycle 1+SETUP_CYC+2k*CLK_DIV and falls CLK_DIV cycles later.
- HOLD: lasts HOLD_CYC cycles, then in one cycle: SSEL=1, MOSI=0, done=1, rx_data<=rx_shift; go to GAP.
- GAP:
  - SSEL stays high for GAP_CYC cycles, then busy=0 and go to IDLE.
  - A start in the same cycle that busy reads 0 is accepted.
- Sampling point: the MISO sample is taken at the SCK rising edge for bit k. The slave changed MISO about 3 clk after the preceding falling edge, or after SSEL fell for bit 0; CLK_DIV>=4 covers this.
- start while busy=1 is ignored entirely; tx_data changes during a frame have no effect.
- Defaults give the following timeline (start accepted at edge 0):
  - SSEL falls at cycle 1.
  - First SCK rise at 5; last SCK fall at 257.
  - SSEL rises and done pulses at 261.
  - busy falls at 265, so the frame period is 265 cycles.
- Counters are 16 bits wide; bitcnt is 5 bits. There is no wrap beyond 31 because the FSM leaves SCK_HI at 31.

Test Plan:
1. Assert rst for 2 cycles, then idle for 10 cycles -> SSEL=1, SCK=0, MOSI=0, busy=0, done=0, rx_data=0x0000 throughout.
2. Loopback with MISO tied to MOSI, tx_data=0xA5C30F1E, start at cycle 0 -> 32 SCK pulses; done at cycle 261 with rx_data=0xA5C3; busy low at 265.
3. Connect to the existing SPI slave model with READ_OUT=0xBEEF, tx_data=0xC0123456 -> slave DATA_OUT=0xC0123456 with one DATA_READY pulse; master rx_data=0xBEEF at done.
4. Timing check with defaults -> SCK rises exactly at cycles 5, 13, ..., 253; MOSI changes only in SCK-falling cycles; SSEL low only over cycles 1-260.
5. Pulse start again at cycle 50, then hold start=1 continuously -> the cycle-50 pulse is ignored; the second frame is accepted at the edge where busy=0 (cycle 265) and its SSEL falls at cycle 266 with a fresh tx_data.
6. Assert rst at cycle 100 mid-frame -> at cycle 101: SSEL=1, SCK=0, busy=0, no done, rx_data unchanged at 0. A following full frame behaves exactly as in scenario 3.

Source files
------------

// File: rtl/spi_master_tx.sv
// 32-bit mode-0 SPI master: one command word per frame, MSB first, with the
// first 16 MISO bits captured as a read-back word.
module spi_master_tx #(
    parameter int CLK_DIV   = 4,
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] tx_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rx_data_o,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        ssel_o,
    input  logic        miso_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCK_HI = 3'd2;
    localparam logic [2:0] ST_SCK_LO = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    logic [2:0]  state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [4:0]  bitcnt_q,   bitcnt_d;
    logic [31:0] tx_shift_q, tx_shift_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] rx_data_q,  rx_data_d;
    logic        launch_q,   launch_d;
    logic        sck_q,      sck_d;
    logic        mosi_q,     mosi_d;
    logic        ssel_q,     ssel_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        miso_q;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        launch_d   = launch_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ssel_d     = ssel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ssel_d = 1'b1;
                sck_d  = 1'b0;
                cnt_d  = 16'd0;
                // An accepted start spends one cycle here with the word
                // latched before SSEL drops; further starts are ignored.
                if (launch_q) begin
                    ssel_d     = 1'b0;
                    mosi_d     = tx_shift_q[31];
                    busy_d     = 1'b1;
                    bitcnt_d   = 5'd0;
                    rx_shift_d = 16'h0000;
                    launch_d   = 1'b0;
                    state_d    = ST_SETUP;
                end else if (start_i) begin
                    tx_shift_d = tx_data_i;
                    launch_d   = 1'b1;
                end else begin
                    launch_d   = 1'b0;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    sck_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_SCK_HI;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end

            ST_SCK_HI: begin
                // First high cycle: miso_q now reflects MISO as it stood
                // just before SCK rose, well after the slave's update.
                if ((cnt_q == 16'd0) && (bitcnt_q < 5'd16)) begin
                    rx_shift_d = {rx_shift_q[14:0], miso_q};
                end else begin
                    rx_shift_d = rx_shift_q;
                end
                if (cnt_q == DIV_LAST) begin
                    sck_d = 1'b0;
                    cnt_d = 16'd0;
                    if (bitcnt_q == 5'd31) begin
                        state_d = ST_HOLD;
                    end else begin
                        bitcnt_d   = bitcnt_q + 5'd1;
                        mosi_d     = tx_shift_q[30];
                        tx_shift_d = {tx_shift_q[30:0], 1'b0};
                        state_d    = ST_SCK_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_SCK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    sck_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_SCK_HI;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    ssel_d    = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    cnt_d     = 16'd0;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d     = cnt_q + 16'd1;
                end
            end

            ST_GAP: begin
                // The cycle busy drops is also a valid start-accept cycle.
                if (cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                    if (start_i) begin
                        tx_shift_d = tx_data_i;
                        launch_d   = 1'b1;
                    end else begin
                        launch_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 16'd0;
                launch_d = 1'b0;
                ssel_d   = 1'b1;
                sck_d    = 1'b0;
                mosi_d   = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            bitcnt_q   <= 5'd0;
            tx_shift_q <= 32'h0000_0000;
            rx_shift_q <= 16'h0000;
            rx_data_q  <= 16'h0000;
            launch_q   <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ssel_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            launch_q   <= launch_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ssel_q     <= ssel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            miso_q     <= miso_i;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign ssel_o    = ssel_q;

endmodule
